round_arbiter_ctrl: RTL and testbench
=====================================

Name: round_arbiter_ctrl

Overview:
Shares one combinational rounding unit (round-to-nearest-even, with exponent-overflow flag) between NUM_REQ upstream datapaths, e.g. adder, multiplier and divider result paths.
- Round-robin arbitration over valid/ready request ports.
- Registers the winning operand set and drives it to the shared rounder.
- Captures the rounder's outputs into a result register tagged with the requester ID.
- Returns results on a single valid/ready result port, full throughput, with backpressure.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
EXPONENT_WIDTH, 8, exponent width
MANTISSA_WIDTH, 23, stored mantissa width
ROUNDING_BITS, 3, guard/round/sticky bits per request (>=2)
(local) ID_W = max(1, $clog2(NUM_REQ))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_exponent  in  NUM_REQ*EXPONENT_WIDTH  packed; requester i at [i*EW +: EW]
req_mantissa  in  NUM_REQ*MANTISSA_WIDTH  packed, same scheme
req_rounding_bits  in  NUM_REQ*ROUNDING_BITS  packed, same scheme
rnd_exponent  out  EXPONENT_WIDTH  to shared rounder, non-rounded exponent
rnd_mantissa  out  MANTISSA_WIDTH  to shared rounder, non-rounded mantissa
rnd_rounding_bits  out  ROUNDING_BITS  to shared rounder
rnd_rounded_exponent  in  EXPONENT_WIDTH  from shared rounder
rnd_rounded_mantissa  in  MANTISSA_WIDTH  from shared rounder
rnd_overflow  in  1  from shared rounder
res_valid  out  1  result valid
res_ready  in  1  result accept
res_id  out  ID_W  index of originating requester
res_exponent  out  EXPONENT_WIDTH  rounded exponent
res_mantissa  out  MANTISSA_WIDTH  rounded mantissa
res_overflow  out  1  rounding overflow flag
busy  out  1  s1_v | s2_v

Behaviour:
- Two register stages.
  - S1: operand register, plus s1_v and s1_id. The rnd_* outputs are driven directly from the S1 register.
  - S2: result register, plus s2_v and s2_id. The res_* outputs are driven directly from S2; res_valid = s2_v.
- Advance rules:
  - s2_adv = s1_v & (~s2_v | res_ready).
  - s1_load = ~s1_v | s2_adv.
  - A request is accepted when req_valid[g] & req_ready[g].
- Arbitration:
  - Grant g = the first i with req_valid[i], scanning from rr_ptr upward modulo NUM_REQ.
  - req_ready[g] = s1_load. All other req_ready bits are 0.
  - req_ready depends combinationally on req_valid; requesters must not make req_valid depend on req_ready.
  - On accept: rr_ptr <= (g+1) mod NUM_REQ. With no accept, rr_ptr holds.
- Throughput and latency:
  - One accept per cycle, sustained when res_ready stays high.
  - Accept at edge E → S1 loaded at E → res_valid high after edge E+1, i.e. 2 cycles accept-to-result.
- Simultaneous load/unload: if S2 drains (res_valid & res_ready) in the same cycle that S1 advances, S2 loads the new result with no bubble.
- Stall:
  - While res_valid & ~res_ready, all res_* outputs and the S1 contents/rnd_* outputs are held stable.
  - If both stages are full, req_ready is all-zero.
- No requests: S1 drains, S2 holds until accepted; rr_ptr unchanged.
- NUM_REQ=1: rr_ptr is constant 0 and res_id is 0.
- Reset (async assert, synchronous deassert from the system reset synchroniser):
  - s1_v, s2_v, rr_ptr, busy, res_valid = 0.
  - All data registers = 0, so rnd_* = 0 and res_* = 0.
  - Reset mid-operation discards in-flight operations; no result is emitted for them.
- The S1 operand is captured verbatim. The rounder result is captured verbatim into S2 on s2_adv.

Optional Feature:
ROUND_ARB_STATS_EN
- Defined: adds outputs stat_ops (32 bits) and stat_ovf (32 bits).
  - stat_ops increments on each result handshake (res_valid & res_ready).
  - stat_ovf increments on each result handshake with res_overflow=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
The bench uses a behavioural round-to-nearest-even model on the rnd_* ports.
- Single request: req_valid=4'b0010, exp=8'h80, mant=23'h000001, rb=3'b110, res_ready=1 → res_valid 2 cycles later; res_id=1, exp=8'h80, mant=23'h000002, ovf=0.
- Fairness: all four req_valid held high, res_ready=1 → accept order 0,1,2,3,0,…; one result per cycle after 2-cycle fill.
- Backpressure: 3 back-to-back requests with res_ready=0 → 2 accepted, then req_ready=0; res_* stable; release res_ready → results in order, third request accepted.
- Overflow: exp=8'hFE, mant=23'h7FFFFF, rb=3'b100 → res_exponent=8'hFF, res_mantissa=0, res_overflow=1.
- Reset mid-flight: assert rst_n=0 with s1_v=s2_v=1 → res_valid, req_ready, busy=0 immediately; after release, rr_ptr=0 and no stale result appears.
- Stats (ROUND_ARB_STATS_EN): 5 results, 2 with overflow → stat_ops=5, stat_ovf=2; counters do not move while stalled.

Source files
------------

// File: rtl/round_arbiter_ctrl.sv
// round_arbiter_ctrl
// Shares one combinational round-to-nearest-even unit between NUM_REQ
// upstream result paths. A round-robin arbiter picks one request per cycle
// into the operand register (S1), which drives the shared rounder directly.
// The rounder output is captured into the result register (S2) together with
// the requester ID and returned on a single valid/ready port.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot or zero)
//   req_exponent/mantissa/rounding_bits   packed operands, requester i at [i*W +: W]
//   rnd_*                  operand to / result from the shared rounder
//   res_valid/res_ready    result handshake; res_id names the originating requester
//   res_exponent/mantissa/overflow        rounded result
//   busy                   either pipeline stage holds an operation
//   stat_ops/stat_ovf      saturating handshake / overflow counters
//                          (present only when ROUND_ARB_STATS_EN is defined)
module round_arbiter_ctrl #(
    parameter int NUM_REQ        = 4,
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ROUNDING_BITS  = 3,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*EXPONENT_WIDTH-1:0]   req_exponent,
    input  logic [NUM_REQ*MANTISSA_WIDTH-1:0]   req_mantissa,
    input  logic [NUM_REQ*ROUNDING_BITS-1:0]    req_rounding_bits,
    output logic [EXPONENT_WIDTH-1:0]           rnd_exponent,
    output logic [MANTISSA_WIDTH-1:0]           rnd_mantissa,
    output logic [ROUNDING_BITS-1:0]            rnd_rounding_bits,
    input  logic [EXPONENT_WIDTH-1:0]           rnd_rounded_exponent,
    input  logic [MANTISSA_WIDTH-1:0]           rnd_rounded_mantissa,
    input  logic                                rnd_overflow,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [ID_W-1:0]                     res_id,
    output logic [EXPONENT_WIDTH-1:0]           res_exponent,
    output logic [MANTISSA_WIDTH-1:0]           res_mantissa,
    output logic                                res_overflow,
    output logic                                busy
`ifdef ROUND_ARB_STATS_EN
    ,
    output logic [31:0]                         stat_ops,
    output logic [31:0]                         stat_ovf
`endif
);
    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
    localparam int RB = ROUNDING_BITS;

    logic            s1_v, s2_v;
    logic [ID_W-1:0] s1_id, s2_id;
    logic [EW-1:0]   s1_exp, s2_exp;
    logic [MW-1:0]   s1_mant, s2_mant;
    logic [RB-1:0]   s1_rb;
    logic            s2_ovf;
    logic [ID_W-1:0] rr_ptr, grant;
    logic            any_req, s1_load, s2_adv, accept;
    int              idx;

    assign s2_adv  = s1_v & (~s2_v | res_ready);
    assign s1_load = ~s1_v | s2_adv;
    assign accept  = any_req & s1_load;

    // Scan downward so the requester closest to rr_ptr is the last to
    // assign grant, i.e. it wins.
    always_comb begin
        grant   = rr_ptr;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                grant   = ID_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
        end
    end

    // S1: operand register feeding the shared rounder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_id   <= '0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_rb   <= '0;
        end else if (s1_load) begin
            s1_v <= any_req;
            if (any_req) begin
                s1_id   <= grant;
                s1_exp  <= req_exponent[int'(grant)*EW +: EW];
                s1_mant <= req_mantissa[int'(grant)*MW +: MW];
                s1_rb   <= req_rounding_bits[int'(grant)*RB +: RB];
            end
        end
    end

    // S2: result register; refills in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_id   <= '0;
            s2_exp  <= '0;
            s2_mant <= '0;
            s2_ovf  <= 1'b0;
        end else if (s2_adv) begin
            s2_v    <= 1'b1;
            s2_id   <= s1_id;
            s2_exp  <= rnd_rounded_exponent;
            s2_mant <= rnd_rounded_mantissa;
            s2_ovf  <= rnd_overflow;
        end else if (res_ready) begin
            s2_v <= 1'b0;
        end
    end

    assign rnd_exponent      = s1_exp;
    assign rnd_mantissa      = s1_mant;
    assign rnd_rounding_bits = s1_rb;

    assign res_valid    = s2_v;
    assign res_id       = s2_id;
    assign res_exponent = s2_exp;
    assign res_mantissa = s2_mant;
    assign res_overflow = s2_ovf;
    assign busy         = s1_v | s2_v;

`ifdef ROUND_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (s2_v && res_ready) begin
            if (stat_ops != '1) stat_ops <= stat_ops + 32'd1;
            if (s2_ovf && stat_ovf != '1) stat_ovf <= stat_ovf + 32'd1;
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_round_arbiter_ctrl.sv
module tb_round_arbiter_ctrl;
    localparam int N   = 4;
    localparam int EW  = 8;
    localparam int MW  = 23;
    localparam int RB  = 3;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [EW-1:0]  e;
        logic [MW-1:0]  m;
        logic           ovf;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*EW-1:0]   req_exponent = '0;
    logic [N*MW-1:0]   req_mantissa = '0;
    logic [N*RB-1:0]   req_rounding_bits = '0;
    logic [EW-1:0]     rnd_exponent, rnd_rounded_exponent;
    logic [MW-1:0]     rnd_mantissa, rnd_rounded_mantissa;
    logic [RB-1:0]     rnd_rounding_bits;
    logic              rnd_overflow;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [IDW-1:0]    res_id;
    logic [EW-1:0]     res_exponent;
    logic [MW-1:0]     res_mantissa;
    logic              res_overflow;
    logic              busy;
`ifdef ROUND_ARB_STATS_EN
    logic [31:0]       stat_ops, stat_ovf;
`endif

    int   checks = 0;
    int   failures = 0;
    res_t sb[$];
    res_t exp_r;
    res_t rmod;

    always #5 clk = ~clk;

    round_arbiter_ctrl #(
        .NUM_REQ(N), .EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW), .ROUNDING_BITS(RB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_exponent(req_exponent), .req_mantissa(req_mantissa),
        .req_rounding_bits(req_rounding_bits),
        .rnd_exponent(rnd_exponent), .rnd_mantissa(rnd_mantissa),
        .rnd_rounding_bits(rnd_rounding_bits),
        .rnd_rounded_exponent(rnd_rounded_exponent),
        .rnd_rounded_mantissa(rnd_rounded_mantissa),
        .rnd_overflow(rnd_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_exponent(res_exponent), .res_mantissa(res_mantissa),
        .res_overflow(res_overflow), .busy(busy)
`ifdef ROUND_ARB_STATS_EN
        , .stat_ops(stat_ops), .stat_ovf(stat_ovf)
`endif
    );

    // Round to nearest, ties to even; a mantissa carry bumps the exponent,
    // and reaching the all-ones exponent flags overflow.
    function automatic res_t rne(input logic [IDW-1:0] id, input logic [EW-1:0] e,
                                 input logic [MW-1:0] m, input logic [RB-1:0] rb);
        res_t       r;
        logic       up;
        logic [MW:0] sum;
        up   = rb[RB-1] & ((|rb[RB-2:0]) | m[0]);
        sum  = {1'b0, m} + {{MW{1'b0}}, up};
        r.id = id;
        if (sum[MW]) begin
            r.e   = e + 1'b1;
            r.m   = '0;
            r.ovf = (&r.e) | (&e);
        end else begin
            r.e   = e;
            r.m   = sum[MW-1:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    // Behavioural shared rounder.
    always_comb rmod = rne('0, rnd_exponent, rnd_mantissa, rnd_rounding_bits);
    assign rnd_rounded_exponent = rmod.e;
    assign rnd_rounded_mantissa = rmod.m;
    assign rnd_overflow         = rmod.ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [EW-1:0] e, input logic [MW-1:0] m,
                           input logic [RB-1:0] rb);
        req_exponent[i*EW +: EW]      = e;
        req_mantissa[i*MW +: MW]      = m;
        req_rounding_bits[i*RB +: RB] = rb;
        req_valid[i]                  = 1'b1;
    endtask

    // Scoreboard: push on accept, pop and compare on result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_result", 64'(sb.size()), 64'd1);
                end else begin
                    exp_r = sb.pop_front();
                    chk("sb_res_id", 64'(res_id), 64'(exp_r.id));
                    chk("sb_res_exponent", 64'(res_exponent), 64'(exp_r.e));
                    chk("sb_res_mantissa", 64'(res_mantissa), 64'(exp_r.m));
                    chk("sb_res_overflow", 64'(res_overflow), 64'(exp_r.ovf));
                end
            end
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i])
                    sb.push_back(rne(IDW'(i), req_exponent[i*EW +: EW],
                                     req_mantissa[i*MW +: MW], req_rounding_bits[i*RB +: RB]));
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rnd_exponent", 64'(rnd_exponent), 64'd0);
        chk("rst_rnd_mantissa", 64'(rnd_mantissa), 64'd0);
        chk("rst_res_exponent", 64'(res_exponent), 64'd0);
        chk("rst_res_mantissa", 64'(res_mantissa), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
`ifdef ROUND_ARB_STATS_EN
        chk("rst_stat_ops", 64'(stat_ops), 64'd0);
`endif
        rst_n = 1'b1;

        // Fairness: all requesters valid, grants rotate 0,1,2,3,...
        step();
        for (int i = 0; i < N; i++)
            set_req(i, EW'(8'h10 + i), MW'($urandom), RB'($urandom));
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_req_ready", 64'(req_ready), 64'(1 << (k % N)));
            chk("fair_res_valid", 64'(res_valid), 64'(k >= 2));
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Single request: two cycles accept-to-result
        set_req(1, 8'h80, 23'h000001, 3'b110);
        #1;
        chk("single_req_ready", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        #1;
        chk("single_rnd_exponent", 64'(rnd_exponent), 64'h80);
        chk("single_rnd_mantissa", 64'(rnd_mantissa), 64'h1);
        chk("single_rnd_rb", 64'(rnd_rounding_bits), 64'b110);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_res_valid_early", 64'(res_valid), 64'd0);
        step();
        chk("single_res_valid", 64'(res_valid), 64'd1);
        chk("single_res_id", 64'(res_id), 64'd1);
        chk("single_res_exponent", 64'(res_exponent), 64'h80);
        chk("single_res_mantissa", 64'(res_mantissa), 64'h2);
        chk("single_res_overflow", 64'(res_overflow), 64'd0);
        step();
        chk("single_drained_valid", 64'(res_valid), 64'd0);
        chk("single_drained_busy", 64'(busy), 64'd0);

        // Overflow
        set_req(0, 8'hFE, 23'h7FFFFF, 3'b100);
        step();
        req_valid = '0;
        step();
        chk("ovf_res_exponent", 64'(res_exponent), 64'hFF);
        chk("ovf_res_mantissa", 64'(res_mantissa), 64'h0);
        chk("ovf_res_overflow", 64'(res_overflow), 64'd1);
        chk("ovf_res_id", 64'(res_id), 64'd0);
        step();

        // Backpressure: A, B, C back to back on requester 3
        res_ready = 1'b0;
        set_req(3, 8'h21, 23'h000100, 3'b011);
        step();
        set_req(3, 8'h22, 23'h000003, 3'b100);
        #1;
        chk("bp_req_ready_b", 64'(req_ready), 64'b1000);
        step();
        set_req(3, 8'h23, 23'h000002, 3'b100);
        #1;
        chk("bp_req_ready_full", 64'(req_ready), 64'd0);
        chk("bp_res_valid", 64'(res_valid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_req_ready", 64'(req_ready), 64'd0);
            chk("bp_hold_res_exponent", 64'(res_exponent), 64'h21);
            chk("bp_hold_res_mantissa", 64'(res_mantissa), 64'h100);
            chk("bp_hold_rnd_exponent", 64'(rnd_exponent), 64'h22);
            chk("bp_hold_rnd_mantissa", 64'(rnd_mantissa), 64'h3);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        #1;
        chk("bp_b_res_exponent", 64'(res_exponent), 64'h22);
        chk("bp_b_res_mantissa", 64'(res_mantissa), 64'h4);
        step();
        chk("bp_c_res_exponent", 64'(res_exponent), 64'h23);
        chk("bp_c_res_mantissa", 64'(res_mantissa), 64'h2);
        step();

        // Reset mid-flight with both stages full
        res_ready = 1'b0;
        set_req(1, 8'h40, 23'h000010, 3'b000);
        step();
        step();
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_res_valid", 64'(res_valid), 64'd1);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_rnd_exponent", 64'(rnd_exponent), 64'd0);
        chk("mid_rst_res_exponent", 64'(res_exponent), 64'd0);
        step();
        rst_n = 1'b1;
        res_ready = 1'b1;
        req_valid = '1;
        #1;
        chk("mid_rr_ptr_zero", 64'(req_ready), 64'b0001);
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid_no_stale", 64'(res_valid), 64'd0);
        end

`ifdef ROUND_ARB_STATS_EN
        // Stats: 5 results, 2 with overflow; frozen while stalled
        for (int k = 0; k < 5; k++) begin
            if (k == 1 || k == 3) set_req(2, 8'hFE, 23'h7FFFFF, 3'b100);
            else                  set_req(2, EW'(8'h30 + k), 23'h000005, 3'b010);
            step();
            req_valid = '0;
        end
        repeat (3) step();
        chk("stat_ops_5", 64'(stat_ops), 64'd5);
        chk("stat_ovf_2", 64'(stat_ovf), 64'd2);
        res_ready = 1'b0;
        set_req(2, 8'hFE, 23'h7FFFFF, 3'b100);
        step();
        req_valid = '0;
        repeat (4) step();
        chk("stat_stall_valid", 64'(res_valid), 64'd1);
        chk("stat_stall_ops", 64'(stat_ops), 64'd5);
        chk("stat_stall_ovf", 64'(stat_ovf), 64'd2);
        res_ready = 1'b1;
        repeat (2) step();
        chk("stat_ops_6", 64'(stat_ops), 64'd6);
        chk("stat_ovf_3", 64'(stat_ovf), 64'd3);
`endif

        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
